// File: rtl/pipe_hazard_ctrl.sv
// ID-stage hazard controller: operand forwarding selects, load-use stall,
// and sequencing of a multi-cycle multiply that is held in ID until done.
module pipe_hazard_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int CW         = 4
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       usea,
    input  logic       useb,
    input  logic       dmul,
    input  logic       ewreg,
    input  logic       em2reg,
    input  logic [4:0] ern,
    input  logic       mwreg,
    input  logic       mm2reg,
    input  logic [4:0] mrn,
    output logic [1:0] fwda,
    output logic [1:0] fwdb,
    output logic       wpcir,
    output logic       dbubble,
    output logic       mstart,
    output logic       busy
);

    typedef enum logic {
        IDLE = 1'b0,
        MULW = 1'b1
    } state_t;

    localparam logic [CW-1:0] CNT_LOAD = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          lu_s;

    // Priority: EX ALU result, then MEM ALU result, then MEM load data.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       ew, input logic em, input logic [4:0] en,
        input logic       mw, input logic mm, input logic [4:0] mn
    );
        logic [1:0] sel;
        if (ew && !em && (en != 5'd0) && (en == src)) begin
            sel = 2'b01;
        end else if (mw && !mm && (mn != 5'd0) && (mn == src)) begin
            sel = 2'b10;
        end else if (mw && mm && (mn != 5'd0) && (mn == src)) begin
            sel = 2'b11;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Forwarding, stall/bubble control and multiply sequencer next state.
    always_comb begin
        lu_s    = ewreg && em2reg && (ern != 5'd0) &&
                  ((usea && (ern == rs)) || (useb && (ern == rt)));
        fwda    = fwd_sel(rs, ewreg, em2reg, ern, mwreg, mm2reg, mrn);
        fwdb    = fwd_sel(rt, ewreg, em2reg, ern, mwreg, mm2reg, mrn);
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        wpcir   = 1'b1;
        dbubble = 1'b0;
        mstart  = 1'b0;
        busy    = 1'b0;
        if (resetn) begin
            fwda    = 2'b00;
            fwdb    = 2'b00;
            dbubble = 1'b1;
            state_d = IDLE;
            cnt_d   = CNT_ZERO;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = CNT_ZERO;
                    if (lu_s) begin
                        wpcir   = 1'b0;
                        dbubble = 1'b1;
                    end else if (dmul && !done_q) begin
                        mstart  = 1'b1;
                        wpcir   = 1'b0;
                        dbubble = 1'b1;
                        state_d = MULW;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        // The finished multiply (if any) advances this cycle.
                        done_d = 1'b0;
                    end
                end
                MULW: begin
                    busy    = 1'b1;
                    wpcir   = 1'b0;
                    dbubble = 1'b1;
                    if (cnt_q > CNT_ONE) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end else begin
                        cnt_d   = CNT_ZERO;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clock) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        done_q  <= done_d;
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench: directed steps followed by random traffic, all
// checked against a cycle-level behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

    localparam int MUL_CYCLES = 4;

    logic       clock;
    logic       resetn;
    logic [4:0] rs, rt, ern, mrn;
    logic       usea, useb, dmul, ewreg, em2reg, mwreg, mm2reg;
    logic [1:0] fwda, fwdb;
    logic       wpcir, dbubble, mstart, busy;

    int passed = 0;
    int total  = 0;

    // Model state: stall cycles still owed to a running multiply, and
    // whether a finished multiply is waiting in ID to advance.
    int mul_left = 0;
    bit mul_done = 0;

    logic s_wpcir, s_mstart, s_busy;

    pipe_hazard_ctrl #(.MUL_CYCLES(MUL_CYCLES), .CW(4)) dut (
        .clock(clock), .resetn(resetn), .rs(rs), .rt(rt), .usea(usea),
        .useb(useb), .dmul(dmul), .ewreg(ewreg), .em2reg(em2reg), .ern(ern),
        .mwreg(mwreg), .mm2reg(mm2reg), .mrn(mrn), .fwda(fwda), .fwdb(fwdb),
        .wpcir(wpcir), .dbubble(dbubble), .mstart(mstart), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [1:0] m_fwd(input logic [4:0] r);
        if (ewreg && !em2reg && ern != 5'd0 && ern == r) return 2'b01;
        if (mwreg && !mm2reg && mrn != 5'd0 && mrn == r) return 2'b10;
        if (mwreg && mm2reg && mrn != 5'd0 && mrn == r)  return 2'b11;
        return 2'b00;
    endfunction

    function automatic bit m_lu();
        return ewreg && em2reg && ern != 5'd0 &&
               ((usea && ern == rs) || (useb && ern == rt));
    endfunction

    task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed=%b expected=%b (t=%0t)", tag, got, exp, $time);
    endtask

    // Check one cycle against the model at mid-cycle, then advance the model.
    task automatic cycle();
        logic [1:0] e_fa, e_fb;
        logic       e_w, e_b, e_m, e_bz;
        #4;
        e_fa = m_fwd(rs); e_fb = m_fwd(rt);
        e_w = 1'b1; e_b = 1'b0; e_m = 1'b0; e_bz = 1'b0;
        if (resetn) begin
            e_fa = 2'b00; e_fb = 2'b00; e_b = 1'b1;
        end else if (mul_left > 0) begin
            e_bz = 1'b1; e_w = 1'b0; e_b = 1'b1;
        end else if (m_lu()) begin
            e_w = 1'b0; e_b = 1'b1;
        end else if (dmul && !mul_done) begin
            e_m = 1'b1; e_w = 1'b0; e_b = 1'b1;
        end
        chk("fwda", fwda, e_fa);
        chk("fwdb", fwdb, e_fb);
        chk("wpcir", {1'b0, wpcir}, {1'b0, e_w});
        chk("dbubble", {1'b0, dbubble}, {1'b0, e_b});
        chk("mstart", {1'b0, mstart}, {1'b0, e_m});
        chk("busy", {1'b0, busy}, {1'b0, e_bz});
        s_wpcir = wpcir; s_mstart = mstart; s_busy = busy;
        @(posedge clock);
        if (resetn) begin
            mul_left = 0; mul_done = 0;
        end else if (mul_left > 0) begin
            mul_left--;
            if (mul_left == 0) mul_done = 1;
        end else if (m_lu()) begin
            mul_left = mul_left;
        end else if (dmul && !mul_done) begin
            mul_left = MUL_CYCLES - 1;
        end else begin
            mul_done = 0;
        end
        #1;
    endtask

    task automatic clear_inputs();
        rs = 5'd0; rt = 5'd0; ern = 5'd0; mrn = 5'd0;
        usea = 1'b0; useb = 1'b0; dmul = 1'b0; ewreg = 1'b0;
        em2reg = 1'b0; mwreg = 1'b0; mm2reg = 1'b0;
    endtask

    initial begin
        int stalls, starts, busys;
        clear_inputs();
        resetn = 1'b1;

        // Reset held two cycles, then released.
        cycle(); chk("rst_wpcir", {1'b0, s_wpcir}, 2'b01);
        cycle(); chk("rst_dbubble", {1'b0, dbubble}, 2'b01);
        resetn = 1'b0;
        cycle(); chk("rel_wpcir", {1'b0, s_wpcir}, 2'b01);

        // Forwarding priority and register 0.
        rs = 5'd5; ewreg = 1'b1; ern = 5'd5; mwreg = 1'b1; mrn = 5'd5;
        cycle(); chk("fwd_ex_wins", fwda, 2'b01);
        ewreg = 1'b0; mm2reg = 1'b1;
        cycle(); chk("fwd_mem_load", fwda, 2'b11);
        mm2reg = 1'b0;
        cycle(); chk("fwd_mem_alu", fwda, 2'b10);
        rs = 5'd0; ern = 5'd0; mrn = 5'd0; ewreg = 1'b1;
        cycle(); chk("fwd_r0", fwda, 2'b00);

        // Load-use on rt, then the same load without useb.
        clear_inputs();
        ewreg = 1'b1; em2reg = 1'b1; ern = 5'd7; rt = 5'd7; useb = 1'b1;
        cycle(); chk("lu_stall", {1'b0, s_wpcir}, 2'b00);
        useb = 1'b0;
        cycle(); chk("lu_none", {1'b0, s_wpcir}, 2'b01);
        chk("lu_fwdb", fwdb, 2'b00);

        // Isolated multiply with dmul held through the release cycle.
        clear_inputs();
        dmul = 1'b1;
        stalls = 0; starts = 0; busys = 0;
        for (int i = 0; i < MUL_CYCLES + 1; i++) begin
            cycle();
            if (!s_wpcir) stalls++;
            if (s_mstart) starts++;
            if (s_busy) busys++;
        end
        chk("mul_release_wpcir", {1'b0, s_wpcir}, 2'b01);
        total++;
        assert (stalls == MUL_CYCLES && starts == 1 && busys == MUL_CYCLES - 1) passed++;
        else $error("FAIL mul_counts: observed stalls=%0d starts=%0d busy=%0d expected %0d/1/%0d",
                    stalls, starts, busys, MUL_CYCLES, MUL_CYCLES - 1);
        dmul = 1'b0;
        cycle();

        // Multiply coinciding with a load-use hazard.
        ewreg = 1'b1; em2reg = 1'b1; ern = 5'd3; rs = 5'd3; usea = 1'b1; dmul = 1'b1;
        cycle(); chk("mul_lu_nostart", {1'b0, s_mstart}, 2'b00);
        ewreg = 1'b0;
        cycle(); chk("mul_lu_start", {1'b0, s_mstart}, 2'b01);
        dmul = 1'b0;
        for (int i = 0; i < MUL_CYCLES; i++) cycle();

        // Reset on the second MULW cycle aborts, then a fresh sequence.
        clear_inputs();
        dmul = 1'b1;
        cycle(); cycle();
        resetn = 1'b1;
        cycle();
        resetn = 1'b0; dmul = 1'b0;
        cycle(); chk("abort_busy", {1'b0, s_busy}, 2'b00);
        chk("abort_mstart", {1'b0, s_mstart}, 2'b00);
        dmul = 1'b1;
        stalls = 0;
        for (int i = 0; i < MUL_CYCLES + 1; i++) begin
            cycle();
            if (!s_wpcir) stalls++;
        end
        total++;
        assert (stalls == MUL_CYCLES) passed++;
        else $error("FAIL fresh_mul_stalls: observed=%0d expected=%0d", stalls, MUL_CYCLES);

        // Random traffic over a small register set to provoke matches.
        for (int i = 0; i < 3000; i++) begin
            resetn = ($urandom_range(0, 63) == 0);
            rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7));
            ern = 5'($urandom_range(0, 7)); mrn = 5'($urandom_range(0, 7));
            usea = 1'($urandom); useb = 1'($urandom);
            dmul = ($urandom_range(0, 3) == 0);
            ewreg = 1'($urandom); em2reg = 1'($urandom);
            mwreg = 1'($urandom); mm2reg = 1'($urandom);
            cycle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard and stall controller for the 5-stage pipeline; lives in the ID stage.
- Drives the forwarding selects for the two ID-stage operand muxes.
- Produces the PC/IF-ID write enable and the bubble control that zeroes the control bits loaded into the ID/EX register.
- Sequences a multi-cycle multiplier by holding the multiply in ID until the multiplier result is ready.

Parameters:
MUL_CYCLES, 4, multiplier latency in cycles; legal range 2..16
CW, 4, internal down-counter width; must satisfy 2^CW > MUL_CYCLES

Ports:
clock  input  1  system clock, rising edge
resetn  input  1  synchronous reset, active-high (1 = reset), sampled on rising clock
rs  input  5  ID-stage source register A number
rt  input  5  ID-stage source register B number
usea  input  1  ID instruction reads rs
useb  input  1  ID instruction reads rt
dmul  input  1  ID instruction is a multi-cycle multiply
ewreg  input  1  EX instruction writes the register file
em2reg  input  1  EX instruction is a load
ern  input  5  EX destination register
mwreg  input  1  MEM instruction writes the register file
mm2reg  input  1  MEM instruction is a load
mrn  input  5  MEM destination register
fwda  output  2  operand A select: 00 regfile, 01 EX ALU, 10 MEM ALU, 11 MEM load data
fwdb  output  2  operand B select, same encoding
wpcir  output  1  PC and IF/ID write enable
dbubble  output  1  1 = load zero control bits into the ID/EX register
mstart  output  1  one-cycle multiplier start pulse
busy  output  1  multiply sequence in progress

Behaviour:
- State register: IDLE or MULW, plus cnt[CW-1:0]. On reset: state=IDLE, cnt=0.
- While resetn=1, outputs are forced: wpcir=1, dbubble=1, mstart=0, busy=0, fwda=fwdb=00.
- Forwarding is combinational and computed identically for fwda (using rs) and fwdb (using rt). First match wins:
  - 01 if ewreg & ~em2reg & ern!=0 & ern==reg.
  - 10 if mwreg & ~mm2reg & mrn!=0 & mrn==reg.
  - 11 if mwreg & mm2reg & mrn!=0 & mrn==reg.
  - 00 otherwise.
  - Forwarding does not depend on usea/useb.
  - Register 0 never forwards.
- Load-use stall (lu), combinational: ewreg & em2reg & ern!=0 & ((usea & ern==rs) | (useb & ern==rt)).
- IDLE:
  - lu=1: wpcir=0, dbubble=1, mstart=0. Stay in IDLE. lu has priority over dmul.
  - lu=0 and dmul=1: mstart=1, wpcir=0, dbubble=1. Next state MULW with cnt=MUL_CYCLES-1.
  - Otherwise: wpcir=1, dbubble=0.
- MULW:
  - busy=1, mstart=0.
  - While cnt>1: wpcir=0, dbubble=1, cnt decrements each cycle.
  - When cnt==1: wpcir=0, dbubble=1, and next state is a one-cycle release in IDLE. In that IDLE cycle dmul is ignored (internal done flag), so the multiply advances to EX with wpcir=1, dbubble=0.
  - Hazards are not re-evaluated in MULW. In the release cycle lu still applies normally.
- Total stall for an isolated multiply: exactly MUL_CYCLES cycles with wpcir=0. mstart is asserted on the first of them only.
- The done flag clears after the release cycle. A back-to-back multiply in the next ID instruction therefore starts a new sequence.
- Reset asserted mid-MULW aborts the sequence: state=IDLE, cnt=0, no further mstart, done flag cleared.
- The counter never wraps. cnt is held at 0 in IDLE.

Test Plan:
- Reset held 2 cycles, then released with all inputs 0 -> during reset wpcir=1, dbubble=1, fwda=fwdb=00; after release wpcir=1, dbubble=0, busy=0.
- rs=5 with ewreg=1, em2reg=0, ern=5 and also mwreg=1, mrn=5 -> fwda=01 (EX wins). Then ewreg=0, mm2reg=1 -> fwda=11. Then rs=0 with matching ern=0 -> fwda=00.
- Load-use: ewreg=1, em2reg=1, ern=7, rt=7, useb=1 -> wpcir=0, dbubble=1 for exactly that cycle. Repeat with useb=0 -> no stall, fwdb=00 since the EX load is not forwardable.
- dmul=1 held, MUL_CYCLES=4 -> mstart high for 1 cycle; wpcir=0 for 4 consecutive cycles; busy=1 for 3 cycles; 5th cycle wpcir=1, dbubble=0, no second mstart.
- dmul=1 together with a load-use hazard in the same cycle -> stall 1 cycle with mstart=0; mstart asserts the following cycle once lu=0.
- Reset asserted on the 2nd MULW cycle -> next cycle state IDLE, busy=0, mstart=0; after release with dmul=1, a fresh 4-cycle sequence starts.
